// File: rtl/ysyx_22051013_bpu_redirect_ctrl_if.sv
// Bundle of signals between the ID-stage BPU, the EX branch unit and the
// redirect controller.
//   pd_*        : prediction records from ID (pd_ready_o stalls ID when low)
//   ex_*        : resolved outcome of the oldest control-flow instruction
//   flush_o     : one-cycle kill of younger instructions
//   redirect_pc_o : corrected fetch PC, valid while flush_o
//   occ_o, br_cnt_o, miss_cnt_o, err_o : status and statistics
// master = pipeline side, slave = redirect controller.
interface ysyx_22051013_bpu_redirect_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             pd_valid_i;
    logic [63:0]      pd_pc_i;
    logic             pd_taken_i;
    logic [63:0]      pd_target_i;
    logic             pd_ready_o;
    logic             ex_valid_i;
    logic [63:0]      ex_pc_i;
    logic             ex_taken_i;
    logic [63:0]      ex_target_i;
    logic             flush_o;
    logic [63:0]      redirect_pc_o;
    logic [OCC_W-1:0] occ_o;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] miss_cnt_o;
    logic             err_o;

    modport master (
        output pd_valid_i, pd_pc_i, pd_taken_i, pd_target_i,
        output ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
        input  pd_ready_o, flush_o, redirect_pc_o, occ_o,
        input  br_cnt_o, miss_cnt_o, err_o
    );

    modport slave (
        input  pd_valid_i, pd_pc_i, pd_taken_i, pd_target_i,
        input  ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
        output pd_ready_o, flush_o, redirect_pc_o, occ_o,
        output br_cnt_o, miss_cnt_o, err_o
    );
endinterface

// File: rtl/ysyx_22051013_bpu_redirect_ctrl.sv
// Prediction tracker / redirect controller.
// Keeps an in-order queue of BPU predictions made in ID and checks each one
// against the EX resolution. A mispredict produces a one-cycle flush with the
// corrected fetch PC, after which all remaining (wrong-path) records are dropped.
// Ports:
//   clk  : core clock
//   rst  : synchronous, active-high reset
//   bus  : slave side of ysyx_22051013_bpu_redirect_ctrl_if (see interface file)
//
// state    | meaning
// ST_RUN   | accepting predictions, checking resolutions
// ST_FLUSH | flush_o high, queue being cleared, all inputs ignored
module ysyx_22051013_bpu_redirect_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    ysyx_22051013_bpu_redirect_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t           state;
    logic [63:0]      q_pc     [DEPTH];
    logic             q_taken  [DEPTH];
    logic [63:0]      q_target [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             flush_q;
    logic [63:0]      redirect_q;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             err_q;

    logic run, empty, full, pop, pc_err, miss, ready, push;
    logic [63:0] redirect_nxt;

    always_comb begin
        run    = (state == ST_RUN);
        empty  = (occ == '0);
        full   = (occ == OCC_W'(DEPTH));
        pop    = run & bus.ex_valid_i & ~empty;
        pc_err = pop & (bus.ex_pc_i != q_pc[rd_ptr]);
        miss   = pop & ((bus.ex_taken_i != q_taken[rd_ptr])
                      | (bus.ex_taken_i & (bus.ex_target_i != q_target[rd_ptr]))
                      | pc_err);
        // A pop frees a slot in the same cycle, so a full queue can still accept.
        ready  = run & (~full | pop);
        // A push alongside a mispredict is on the wrong path and is discarded.
        push   = bus.pd_valid_i & ready & ~miss;
        redirect_nxt = bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_i + 64'd4;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]     <= bus.pd_pc_i;
            q_taken[wr_ptr]  <= bus.pd_taken_i;
            q_target[wr_ptr] <= bus.pd_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            br_cnt     <= '0;
            miss_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    flush_q <= 1'b0;
                    if ((bus.ex_valid_i & empty) | pc_err)
                        err_q <= 1'b1;
                    if (pop) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                        if (br_cnt != '1)
                            br_cnt <= br_cnt + CNT_W'(1);
                    end
                    if (push)
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    case ({push, pop})
                        2'b10:   occ <= occ + OCC_W'(1);
                        2'b01:   occ <= occ - OCC_W'(1);
                        default: occ <= occ;
                    endcase
                    if (miss) begin
                        if (miss_cnt != '1)
                            miss_cnt <= miss_cnt + CNT_W'(1);
                        redirect_q <= redirect_nxt;
                        flush_q    <= 1'b1;
                        state      <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    flush_q <= 1'b0;
                    wr_ptr  <= '0;
                    rd_ptr  <= '0;
                    occ     <= '0;
                    state   <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.pd_ready_o    = ready;
    assign bus.flush_o       = flush_q;
    assign bus.redirect_pc_o = redirect_q;
    assign bus.occ_o         = occ;
    assign bus.br_cnt_o      = br_cnt;
    assign bus.miss_cnt_o    = miss_cnt;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_ysyx_22051013_bpu_redirect_ctrl.sv
module tb_ysyx_22051013_bpu_redirect_ctrl;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22051013_bpu_redirect_ctrl_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    ysyx_22051013_bpu_redirect_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] tgt;
    } pred_t;

    typedef struct {
        logic        miss;
        logic [63:0] redir;
    } exp_t;

    pred_t mq[$];
    exp_t  sb[$];
    logic        m_flush_st;
    logic [31:0] m_br, m_miss;
    logic        m_err;
    logic [63:0] m_redir;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [63:0] ppc, input logic ptk,
                         input logic [63:0] ptg, input logic ev, input logic [63:0] epc,
                         input logic etk, input logic [63:0] etg);
        bus.pd_valid_i  = pv;
        bus.pd_pc_i     = ppc;
        bus.pd_taken_i  = ptk;
        bus.pd_target_i = ptg;
        bus.ex_valid_i  = ev;
        bus.ex_pc_i     = epc;
        bus.ex_taken_i  = etk;
        bus.ex_target_i = etg;
    endtask

    // One clock: model the cycle, check combinational ready, then the
    // registered outputs #1 after the rising edge.
    task automatic tick();
        logic pop, miss, pc_bad, ready, push, empty_err;
        logic [63:0] redir;
        pred_t h, np;
        exp_t e;
        #1;
        pop = 1'b0; miss = 1'b0; pc_bad = 1'b0; empty_err = 1'b0;
        if (!m_flush_st && bus.ex_valid_i) begin
            if (mq.size() == 0) empty_err = 1'b1;
            else begin
                pop = 1'b1;
                h = mq[0];
                pc_bad = (bus.ex_pc_i != h.pc);
                miss = pc_bad || (bus.ex_taken_i != h.taken) ||
                       (bus.ex_taken_i && bus.ex_target_i != h.tgt);
            end
        end
        redir = bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_i + 64'd4;
        ready = !m_flush_st && (mq.size() < DEPTH || pop);
        push  = bus.pd_valid_i && ready && !miss;
        if (!rst) begin
            chk("pd_ready", {63'd0, bus.pd_ready_o}, {63'd0, ready});
            if (pop) begin
                e.miss = miss; e.redir = redir;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        if (rst) begin
            mq.delete(); m_flush_st = 1'b0; m_br = 0; m_miss = 0; m_err = 1'b0; m_redir = '0;
        end else if (m_flush_st) begin
            mq.delete(); m_flush_st = 1'b0;
        end else begin
            if (empty_err || (pop && pc_bad)) m_err = 1'b1;
            if (pop) begin
                void'(mq.pop_front());
                if (m_br != 32'hffff_ffff) m_br++;
                if (miss) begin
                    if (m_miss != 32'hffff_ffff) m_miss++;
                    m_redir = redir;
                    m_flush_st = 1'b1;
                end
            end
            if (push) begin
                np.pc = bus.pd_pc_i; np.taken = bus.pd_taken_i; np.tgt = bus.pd_target_i;
                mq.push_back(np);
            end
        end
        #1;
        if (rst || sb.size() == 0) begin
            sb.delete();
            chk("flush_idle", {63'd0, bus.flush_o}, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("flush", {63'd0, bus.flush_o}, {63'd0, e.miss});
            if (e.miss) chk("redirect_sb", bus.redirect_pc_o, e.redir);
        end
        chk("redirect_hold", bus.redirect_pc_o, m_redir);
        chk("occ", {61'd0, bus.occ_o}, 64'(mq.size()));
        chk("br_cnt", {32'd0, bus.br_cnt_o}, {32'd0, m_br});
        chk("miss_cnt", {32'd0, bus.miss_cnt_o}, {32'd0, m_miss});
        chk("err", {63'd0, bus.err_o}, {63'd0, m_err});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        m_flush_st = 1'b0; m_br = 0; m_miss = 0; m_err = 1'b0; m_redir = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        idle(1);

        // correct taken prediction
        drive(1, 64'h8000_0000, 1, 64'h8000_0010, 0, 0, 0, 0); tick();
        chk("t1_occ1", {61'd0, bus.occ_o}, 64'd1);
        drive(0, 0, 0, 0, 1, 64'h8000_0000, 1, 64'h8000_0010); tick();
        chk("t1_br", {32'd0, bus.br_cnt_o}, 64'd1);
        idle(1);

        // predicted not-taken, actually taken
        drive(1, 64'h8000_0020, 0, 64'h8000_0024, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 64'h8000_0020, 1, 64'h8000_0008); tick();
        chk("t2_redirect", bus.redirect_pc_o, 64'h8000_0008);
        idle(2);

        // predicted taken, actually not-taken, with a wrong-path push
        drive(1, 64'h200, 1, 64'h100, 0, 0, 0, 0); tick();
        drive(1, 64'h300, 0, 64'h304, 1, 64'h200, 0, 0); tick();
        chk("t3_redirect", bus.redirect_pc_o, 64'h204);
        idle(1);
        chk("t3_occ0", {61'd0, bus.occ_o}, 64'd0);
        idle(1);

        // fill, stall, push+pop while full, drain
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 64'h1000 + 64'(16 * i), 1, 64'h1008 + 64'(16 * i), 0, 0, 0, 0);
            tick();
        end
        drive(1, 64'h1040, 1, 64'h1048, 0, 0, 0, 0); tick();
        drive(1, 64'h1040, 1, 64'h1048, 1, 64'h1000, 1, 64'h1008); tick();
        chk("t4_occ_full", {61'd0, bus.occ_o}, 64'd4);
        for (int i = 1; i <= DEPTH; i++) begin
            drive(0, 0, 0, 0, 1, 64'h1000 + 64'(16 * i), 1, 64'h1008 + 64'(16 * i));
            tick();
        end
        idle(1);

        // resolve with empty queue, then a PC mismatch
        drive(0, 0, 0, 0, 1, 64'h400, 0, 0); tick();
        idle(1);
        drive(1, 64'h500, 0, 64'h504, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 64'h508, 0, 0); tick();
        idle(2);

        // reset during the flush cycle
        drive(1, 64'h600, 1, 64'h700, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 64'h600, 1, 64'h780); tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        rst = 1'b0;
        idle(2);

        // random traffic against the model
        for (int i = 0; i < 200; i++) begin
            logic [63:0] epc, etg, ppc;
            logic etk;
            ppc = 64'(($urandom_range(0, 255)) * 4);
            epc = (mq.size() > 0 && $urandom_range(0, 7) != 0) ? mq[0].pc : 64'(($urandom_range(0, 255)) * 4);
            etk = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].taken : 1'($urandom_range(0, 1));
            etg = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].tgt : 64'(($urandom_range(0, 255)) * 4);
            drive(1'($urandom_range(0, 1)), ppc, 1'($urandom_range(0, 1)), ppc + 64'h40,
                  ($urandom_range(0, 2) == 0), epc, etk, etg);
            tick();
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
